// File: rtl/ip4_spa_pkg.sv
// Shared types and sizing for the IP4 SPA op interface.
// Both the issue stage and the SPA take their depth and credit limits from here.
package ip4_spa_pkg;

   localparam int OP_W        = 32;
   localparam int WID_W       = 3;
   localparam int SPA_DEPTH   = 4;
   localparam int SPA_MAX_OUT = 4;

   typedef logic [OP_W-1:0]  op_t;
   typedef logic [WID_W-1:0] wid_t;

   typedef struct packed {
      op_t  op;
      wid_t wid;
   } spa_req_t;

endpackage

// File: rtl/ip4_rtl_spa_issue_if.sv
// Decoder-to-issue and issue-to-SPA handshake bundle.
// The master modport is the surrounding pipeline; slave is the issue stage.
interface ip4_rtl_spa_issue_if;
   import ip4_spa_pkg::*;

   logic dec_vld;
   op_t  dec_op;
   wid_t dec_wid;
   logic dec_rdy;
   logic spa_vld;
   op_t  spa_op;
   wid_t spa_wid;
   logic spa_rdy;
   logic spa_cmt;

   modport master (
      output dec_vld, dec_op, dec_wid, spa_rdy, spa_cmt,
      input  dec_rdy, spa_vld, spa_op, spa_wid
   );

   modport slave (
      input  dec_vld, dec_op, dec_wid, spa_rdy, spa_cmt,
      output dec_rdy, spa_vld, spa_op, spa_wid
   );

endinterface

// File: rtl/ip4_rtl_spa_fifo.sv
// In-order op FIFO for the SPA issue stage. A flush empties it, optionally
// retaining the head entry so a presented op is never withdrawn.
module ip4_rtl_spa_fifo
   import ip4_spa_pkg::*;
#(
   parameter int DEPTH = SPA_DEPTH
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  spa_req_t wr_data,
   input  logic     pop,
   input  logic     flush,
   input  logic     flush_keep_head,
   output logic     empty,
   output logic     full,
   output spa_req_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   spa_req_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;
   logic             keep;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full && !flush;
   assign keep    = flush_keep_head && !empty && !do_pop;

   // Control state: pointers wrap modulo DEPTH, count tells full from empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= rd_ptr + PTR_W'(do_pop);
         wr_ptr <= rd_ptr + PTR_W'(do_pop | keep);
         count  <= CNT_W'(keep);
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr];
   end

endmodule

// File: rtl/ip4_rtl_spa_issue.sv
// SPA issue stage: buffers decoded ops, presents them with valid/ready and
// bounds in-flight ops with a credit counter refilled by SPA commit pulses.
module ip4_rtl_spa_issue
   import ip4_spa_pkg::*;
#(
   parameter  int DEPTH   = SPA_DEPTH,
   parameter  int MAX_OUT = SPA_MAX_OUT,
   localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ip4_rtl_spa_issue_if.slave   bus,
   input  logic                 flush,
   output logic [OUT_W-1:0]     out_cnt,
   output logic                 idle,
   output logic                 err_cmt
);

   logic     empty;
   logic     full;
   logic     held_p0;
   logic     credit_ok;
   logic     do_push;
   logic     issue;
   spa_req_t wr_data;
   spa_req_t head;

   function automatic logic [OUT_W-1:0] credit_next(
      input logic [OUT_W-1:0] cnt,
      input logic             inc,
      input logic             dec
   );
      logic [OUT_W-1:0] r;
      r = cnt;
      if (inc && !dec && cnt != OUT_W'(MAX_OUT))
         r = cnt + OUT_W'(1);
      else if (dec && !inc && cnt != '0)
         r = cnt - OUT_W'(1);
      return r;
   endfunction

   assign wr_data     = '{op: bus.dec_op, wid: bus.dec_wid};
   assign bus.dec_rdy = !full && !flush;
   assign do_push     = bus.dec_vld && bus.dec_rdy;

   // A held op stays presented even at the credit ceiling.
   assign credit_ok   = (out_cnt < OUT_W'(MAX_OUT));
   assign bus.spa_vld = !empty && (credit_ok || held_p0);
   assign bus.spa_op  = head.op;
   assign bus.spa_wid = head.wid;
   assign issue       = bus.spa_vld && bus.spa_rdy;

   assign idle = empty && (out_cnt == '0);

   ip4_rtl_spa_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk             (clk),
      .rst_n           (rst_n),
      .push            (do_push),
      .wr_data         (wr_data),
      .pop             (issue),
      .flush           (flush),
      .flush_keep_head (bus.spa_vld),
      .empty           (empty),
      .full            (full),
      .head            (head)
   );

   // Credit, hold and error state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_cnt <= '0;
         held_p0 <= 1'b0;
         err_cmt <= 1'b0;
      end else begin
         held_p0 <= bus.spa_vld && !bus.spa_rdy;
         out_cnt <= credit_next(out_cnt, issue, bus.spa_cmt);
         if (bus.spa_cmt && out_cnt == '0) err_cmt <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ip4_rtl_spa_issue.sv
// Bench for the SPA issue stage: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_ip4_rtl_spa_issue;
  import ip4_spa_pkg::*;

  localparam int DEPTH   = SPA_DEPTH;
  localparam int MAX_OUT = SPA_MAX_OUT;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [OUT_W-1:0] out_cnt;
  logic             idle;
  logic             err_cmt;

  ip4_rtl_spa_issue_if bus();

  ip4_rtl_spa_issue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flush   (flush),
    .out_cnt (out_cnt),
    .idle    (idle),
    .err_cmt (err_cmt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  spa_req_t    mq[$];
  int          m_out;
  bit          m_held;
  bit          m_err;
  logic [31:0] iss_q[$];

  bit   c_dv, c_rdy, c_cmt, c_fl;
  op_t  c_op;
  wid_t c_wid;
  bit   e_vld, e_drdy;

  typedef struct {
    bit          dv;
    logic [31:0] op;
    logic [2:0]  wid;
    bit          rdy;
    bit          cmt;
    bit          e_drdy;
    bit          e_vld;
    logic [31:0] e_op;
    logic [2:0]  e_wid;
    int          e_cnt;
    bit          e_idle;
    bit          e_err;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit dv, logic [31:0] op, logic [2:0] wid, bit rdy, bit cmt,
                              bit e_drdy, bit e_vld, logic [31:0] e_op, logic [2:0] e_wid,
                              int e_cnt, bit e_idle, bit e_err);
    vec_t v;
    v.dv = dv; v.op = op; v.wid = wid; v.rdy = rdy; v.cmt = cmt;
    v.e_drdy = e_drdy; v.e_vld = e_vld; v.e_op = e_op; v.e_wid = e_wid;
    v.e_cnt = e_cnt; v.e_idle = e_idle; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input bit dv, input logic [31:0] op, input logic [2:0] wid,
                       input bit rdy, input bit cmt, input bit fl);
    bus.dec_vld = dv; bus.dec_op = op; bus.dec_wid = wid;
    bus.spa_rdy = rdy; bus.spa_cmt = cmt; flush = fl;
    c_dv = dv; c_op = op; c_wid = wid; c_rdy = rdy; c_cmt = cmt; c_fl = fl;
    #4;
    e_vld  = (mq.size() != 0) && (m_out < MAX_OUT || m_held);
    e_drdy = (mq.size() < DEPTH) && !fl;
    chk("m_dec_rdy", bus.dec_rdy, e_drdy);
    chk("m_spa_vld", bus.spa_vld, e_vld);
    if (e_vld) begin
      chk("m_spa_op", bus.spa_op, mq[0].op);
      chk("m_spa_wid", bus.spa_wid, mq[0].wid);
    end
    chk("m_out_cnt", out_cnt, m_out);
    chk("m_idle", idle, (mq.size() == 0) && (m_out == 0));
    chk("m_err_cmt", err_cmt, m_err);
  endtask

  task automatic advance();
    bit issue;
    spa_req_t h;
    if (bus.spa_vld && c_rdy) iss_q.push_back(bus.spa_op);
    issue = e_vld && c_rdy;
    if (issue) h = mq.pop_front();
    if (c_fl) begin
      if (e_vld && !issue) begin
        h = mq[0];
        mq.delete();
        mq.push_back(h);
      end else begin
        mq.delete();
      end
    end else if (c_dv && e_drdy) begin
      mq.push_back('{op: c_op, wid: c_wid});
    end
    if (c_cmt && m_out == 0) m_err = 1'b1;
    else m_out = m_out + int'(issue) - int'(c_cmt);
    m_held = e_vld && !c_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit dv, input logic [31:0] op, input logic [2:0] wid,
                      input bit rdy, input bit cmt, input bit fl);
    apply(dv, op, wid, rdy, cmt, fl);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dec_vld = 0; bus.dec_op = '0; bus.dec_wid = '0;
    bus.spa_rdy = 0; bus.spa_cmt = 0; flush = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    iss_q.delete();
    m_out = 0; m_held = 0; m_err = 0;
  endtask

  function automatic logic [63:0] iss_at(int k);
    if (k < iss_q.size()) return 64'(iss_q[k]);
    return 64'hDEAD_DEAD;
  endfunction

  initial begin
    int pushed;
    tbl[0]  = mk(1, 32'h11, 2, 1, 0,  1, 0, 32'h0,  0, 0, 1, 0);
    tbl[1]  = mk(0, 32'h0,  0, 1, 0,  1, 1, 32'h11, 2, 0, 0, 0);
    tbl[2]  = mk(0, 32'h0,  0, 1, 0,  1, 0, 32'h0,  0, 1, 0, 0);
    tbl[3]  = mk(0, 32'h0,  0, 1, 1,  1, 0, 32'h0,  0, 1, 0, 0);
    tbl[4]  = mk(0, 32'h0,  0, 1, 0,  1, 0, 32'h0,  0, 0, 1, 0);
    tbl[5]  = mk(1, 32'h21, 1, 1, 0,  1, 0, 32'h0,  0, 0, 1, 0);
    tbl[6]  = mk(1, 32'h22, 2, 1, 0,  1, 1, 32'h21, 1, 0, 0, 0);
    tbl[7]  = mk(1, 32'h23, 3, 1, 0,  1, 1, 32'h22, 2, 1, 0, 0);
    tbl[8]  = mk(0, 32'h0,  0, 1, 1,  1, 1, 32'h23, 3, 2, 0, 0);
    tbl[9]  = mk(0, 32'h0,  0, 0, 0,  1, 0, 32'h0,  0, 2, 0, 0);
    tbl[10] = mk(0, 32'h0,  0, 0, 1,  1, 0, 32'h0,  0, 2, 0, 0);
    tbl[11] = mk(0, 32'h0,  0, 0, 1,  1, 0, 32'h0,  0, 1, 0, 0);
    tbl[12] = mk(0, 32'h0,  0, 0, 1,  1, 0, 32'h0,  0, 0, 1, 0);
    tbl[13] = mk(0, 32'h0,  0, 0, 0,  1, 0, 32'h0,  0, 0, 1, 1);

    do_reset();
    apply(0, 0, 0, 0, 0, 0);
    chk("rst_spa_vld", bus.spa_vld, 0);
    chk("rst_dec_rdy", bus.dec_rdy, 1);
    chk("rst_idle", idle, 1);
    chk("rst_spa_op", bus.spa_op, 0);
    chk("rst_spa_wid", bus.spa_wid, 0);
    advance();

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].dv, tbl[i].op, tbl[i].wid, tbl[i].rdy, tbl[i].cmt, 0);
      chk($sformatf("t%0d_dec_rdy", i), bus.dec_rdy, tbl[i].e_drdy);
      chk($sformatf("t%0d_spa_vld", i), bus.spa_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("t%0d_spa_op", i), bus.spa_op, tbl[i].e_op);
        chk($sformatf("t%0d_spa_wid", i), bus.spa_wid, tbl[i].e_wid);
      end
      chk($sformatf("t%0d_out_cnt", i), out_cnt, tbl[i].e_cnt);
      chk($sformatf("t%0d_idle", i), idle, tbl[i].e_idle);
      chk($sformatf("t%0d_err_cmt", i), err_cmt, tbl[i].e_err);
      advance();
    end

    // err_cmt sticks until reset
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0, 0);
    chk("err_sticky", err_cmt, 1);
    do_reset();
    apply(0, 0, 0, 0, 0, 0);
    chk("err_cleared", err_cmt, 0);
    advance();

    // Fill to DEPTH with SPA stalled, then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1, 32'h100 + i, 3'(i), 0, 0, 0);
      if (i == 4) chk("full_dec_rdy", bus.dec_rdy, 0);
      if (i >= 1) begin
        chk("full_vld_stable", bus.spa_vld, 1);
        chk("full_op_stable", bus.spa_op, 32'h100);
      end
      advance();
    end
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 1, 0, 0);
    chk("full_issue_cnt", iss_q.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("full_order%0d", k), iss_at(k), 64'(32'h100 + k));

    // Credit ceiling with 6 ops offered and no commits
    do_reset();
    pushed = 0;
    for (int i = 0; i < 14; i++) begin
      apply(pushed < 6, 32'h200 + pushed, 3'(pushed), 1, 0, 0);
      if (pushed < 6 && bus.dec_rdy) pushed++;
      advance();
    end
    apply(0, 0, 0, 1, 0, 0);
    chk("ceil_pushed", pushed, 6);
    chk("ceil_issues", iss_q.size(), 4);
    chk("ceil_out_cnt", out_cnt, 4);
    chk("ceil_spa_vld", bus.spa_vld, 0);
    advance();
    tick(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    chk("ceil_issues_after_cmt", iss_q.size(), 5);
    chk("ceil_out_after_cmt", out_cnt, 4);
    chk("ceil_fifth_op", iss_at(4), 64'h204);
    advance();

    // Flush while the head is presented keeps only the head
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 32'h300 + i, 3'(i), 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0);
    chk("flush_head_vld", bus.spa_vld, 1);
    chk("flush_head_op", bus.spa_op, 32'h300);
    advance();
    tick(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    chk("flush_empty_vld", bus.spa_vld, 0);
    chk("flush_out_cnt", out_cnt, 1);
    chk("flush_not_idle", idle, 0);
    advance();
    tick(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    chk("flush_idle", idle, 1);
    chk("flush_single_issue", iss_q.size(), 1);
    advance();

    // Reset mid-stream with 3 in flight and 2 queued
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 32'h400 + i, 3'(i), 1, 0, 0);
    tick(1, 32'h404, 3'd4, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("mid_out_cnt_pre", out_cnt, 3);
    advance();
    do_reset();
    apply(0, 0, 0, 0, 0, 0);
    chk("mid_spa_vld", bus.spa_vld, 0);
    chk("mid_out_cnt", out_cnt, 0);
    chk("mid_dec_rdy", bus.dec_rdy, 1);
    chk("mid_idle", idle, 1);
    chk("mid_err_cmt", err_cmt, 0);
    advance();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit dv, rdy, cmt, fl;
      dv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      cmt = (m_out > 0) && ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      tick(dv, $urandom, 3'($urandom_range(0, 7)), rdy, cmt, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ip4_rtl_spa_issue.md
Name: ip4_rtl_spa_issue

Overview:
- Issue stage on the sending end of the IP4 stream processor array (SPA) op interface.
- Buffers decoded ops from the decoder in an in-order FIFO and presents them to the SPA with a valid/ready handshake.
- Limits in-flight ops with a credit counter; credits return on SPA commit pulses.
- Reports idle and protocol-error status to the pipeline controller.

Parameters:
- OP_W, 32, width of one decoded op word.
- WID_W, 3, width of the thread-group id attached to each op.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- MAX_OUT, 4, maximum ops issued to the SPA and not yet committed.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dec_vld  in  1  decoder offers an op.
- dec_op  in  OP_W  op word.
- dec_wid  in  WID_W  thread-group id.
- dec_rdy  out  1  issue stage accepts the offered op.
- spa_vld  out  1  op presented to SPA.
- spa_op  out  OP_W  head op word.
- spa_wid  out  WID_W  head thread-group id.
- spa_rdy  in  1  SPA accepts the presented op.
- spa_cmt  in  1  one-cycle pulse; SPA retired one op and returns one credit.
- flush  in  1  discard queued, unpresented ops.
- out_cnt  out  $clog2(MAX_OUT+1)  ops currently in flight.
- idle  out  1  FIFO empty and out_cnt==0.
- err_cmt  out  1  sticky; set when spa_cmt arrives while out_cnt==0.

Behaviour:
- Reset (rst_n low at clk edge):
  - FIFO empty, pointers 0, out_cnt=0, err_cmt=0.
  - Resulting outputs: spa_vld=0, dec_rdy=1, idle=1; spa_op/spa_wid=0.
  - Reset mid-operation drops all queued and in-flight state; no completion is expected afterwards.
- Accept: push when dec_vld && dec_rdy.
  - dec_rdy = !full && !flush. Registered fill count only; no same-cycle pass-through at full.
- Latency: an op pushed in cycle N is presentable on spa_vld in cycle N+1 at the earliest. There is no bypass path.
- Present: spa_vld = !empty && (out_cnt < MAX_OUT || held).
  - "held" is a flag set when spa_vld=1 and spa_rdy=0; it is cleared on acceptance.
  - Once spa_vld rises, it and spa_op/spa_wid stay stable until spa_rdy. Credit state never withdraws a presented op.
- Issue: spa_vld && spa_rdy pops the FIFO head and increments out_cnt.
- Commit: spa_cmt decrements out_cnt.
  - Issue and commit in the same cycle leave out_cnt unchanged.
  - spa_cmt with out_cnt==0: out_cnt stays 0 and err_cmt is set, held until reset.
- Credit ceiling: when out_cnt==MAX_OUT and nothing is held, spa_vld=0. Presentation resumes the cycle after a spa_cmt.
- Flush (level, evaluated per cycle):
  - Empties the FIFO, except that a head currently presented (spa_vld=1) is retained until accepted.
  - A push in the same cycle is refused (dec_rdy=0).
  - An issue in the same cycle completes normally.
  - out_cnt is unaffected; in-flight ops still commit.
- Push and pop in the same cycle at any fill level other than full: count unchanged, order preserved.
- Pointer wrap is modulo DEPTH. Full/empty are distinguished by a $clog2(DEPTH)+1-bit count.
- idle is combinational from registered state.

Decomposition:
- Package ip4_spa_pkg holds:
  - op_t (logic [OP_W-1:0]) and wid_t (logic [WID_W-1:0]);
  - packed struct spa_req_t {op_t op; wid_t wid;};
  - constants SPA_DEPTH and SPA_MAX_OUT, used by this block and by the SPA.
- One sub-module, ip4_rtl_spa_fifo:
  - synchronous FIFO of spa_req_t with push, pop, flush_keep_head and rst_n;
  - outputs empty, full and head.
- Handshake, credit and error logic stay in the top module.

Test Plan:
- Reset, then push op 0x11 wid 2, spa_rdy=1 -> spa_vld rises one cycle after push with spa_op=0x11, spa_wid=2; out_cnt=1; idle=0.
- Push 5 ops back-to-back with spa_rdy=0, DEPTH=4 -> 4 accepted, dec_rdy=0 on the 5th; spa_vld=1 and spa_op stable throughout. Releasing spa_rdy drains the ops in order.
- spa_rdy=1, no commits, 6 ops queued, MAX_OUT=4 -> exactly 4 issues, then spa_vld=0 with out_cnt=4. One spa_cmt pulse -> exactly one further issue, and out_cnt returns to 4.
- Issue and spa_cmt in the same cycle with out_cnt=2 -> out_cnt stays 2. spa_cmt with out_cnt=0 -> err_cmt=1 and stays 1 until rst_n low.
- 3 ops queued, head presented with spa_rdy=0, flush for 1 cycle -> only the head remains. spa_rdy=1 -> it issues, then the FIFO is empty and idle follows once the outstanding commits arrive.
- Assert rst_n=0 mid-stream with out_cnt=3 and FIFO half full -> next cycle spa_vld=0, out_cnt=0, dec_rdy=1, idle=1, err_cmt=0.
